// File: rtl/parity_serial_tx.sv
// Parity-generating serial framing transmitter: start bit, LSB-first data, parity bit, stop bit.
// Define TX_DOUBLE_STOP_EN to send two stop bits per frame.
module parity_serial_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

`ifdef TX_DOUBLE_STOP_EN
  localparam int STOP_CYCLES = 2 * BIT_CYCLES;
`else
  localparam int STOP_CYCLES = BIT_CYCLES;
`endif

  localparam int CW = $clog2(STOP_CYCLES + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [BW-1:0]     bit_r, bit_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              par_r, par_s;
  logic              done_s;
  logic              last_s;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    logic p;
    p = ^d;
    if (PARITY_ODD != 0) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

  function automatic logic line_level(input logic [2:0] st, input logic s0, input logic p);
    logic l;
    case (st)
      ST_IDLE:   l = 1'b1;
      ST_START:  l = 1'b0;
      ST_DATA:   l = s0;
      ST_PARITY: l = p;
      ST_STOP:   l = 1'b1;
      default:   l = 1'b1;
    endcase
    return l;
  endfunction

  // Next-state, counter and shift-register logic for one frame.
  always_comb begin
    state_s = state_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    done_s  = 1'b0;
    if (state_r == ST_STOP) begin
      last_s = (cnt_r == STOP_LAST);
    end else begin
      last_s = (cnt_r == BIT_LAST);
    end
    case (state_r)
      ST_IDLE: begin
        if (valid_in) begin
          state_s = ST_START;
          shift_s = data_in;
          par_s   = calc_parity(data_in);
          bit_s   = {BW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (last_s) state_s = ST_DATA;
        else        state_s = ST_START;
      end
      ST_DATA: begin
        if (last_s && (bit_r == DATA_LAST)) begin
          state_s = ST_PARITY;
          bit_s   = {BW{1'b0}};
        end else if (last_s) begin
          shift_s = shift_r >> 1;
          bit_s   = bit_r + {{(BW-1){1'b0}}, 1'b1};
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (last_s) state_s = ST_STOP;
        else        state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (last_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Counter restarts on every bit boundary and sits at zero while idle.
    if ((state_r == ST_IDLE) || last_s) begin
      cnt_s = {CW{1'b0}};
    end else begin
      cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State registers; outputs are registered from the next-state decode so they never see valid_in combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_r     <= {BW{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_r     <= 1'b0;
      tx_out    <= 1'b1;
      ready_out <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      tx_out    <= line_level(state_s, shift_s[0], par_s);
      ready_out <= (state_s == ST_IDLE);
      busy      <= (state_s != ST_IDLE);
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed self-checking bench for parity_serial_tx: an even-parity and an odd-parity instance.
module tb_parity_serial_tx;
  localparam int DW = 4;
  localparam int BC = 4;
`ifdef TX_DOUBLE_STOP_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif
  localparam int FL = (DW + 2 + SB) * BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data0 = 4'd0, data1 = 4'd0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data0), .valid_in(valid0),
    .ready_out(ready0), .tx_out(tx0), .busy(busy0), .done(done0));

  parity_serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .valid_in(valid1),
    .ready_out(ready1), .tx_out(tx1), .busy(busy1), .done(done1));

  function automatic logic [127:0] mask(input int n);
    logic [127:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected line: start 0, data LSB-first, parity, stop high, each held BC clocks.
  function automatic logic [127:0] put_frame(input logic [127:0] base, input logic [3:0] d,
                                             input logic p, input int start);
    logic [127:0] v = base;
    for (int i = 0; i < FL; i++) begin
      int b = i / BC;
      if (b == 0)            v[start+i] = 1'b0;
      else if (b <= DW)      v[start+i] = d[b-1];
      else if (b == DW + 1)  v[start+i] = p;
      else                   v[start+i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [127:0] span(input int start, input int len);
    logic [127:0] v = '0;
    for (int i = 0; i < len; i++) v[start+i] = 1'b1;
    return v;
  endfunction

  task automatic send(input bit sel, input logic [3:0] d);
    @(negedge clk);
    if (sel) begin data1 = d; valid1 = 1'b1; end
    else     begin data0 = d; valid0 = 1'b1; end
  endtask

  task automatic capture(input bit sel, input int n, input int drop_at, input int swap_at,
                         input logic [3:0] swap_d, output logic [127:0] txv,
                         output logic [127:0] bv, output logic [127:0] rv, output logic [127:0] dv);
    txv = '0; bv = '0; rv = '0; dv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txv[i] = sel ? tx1 : tx0;
      bv[i]  = sel ? busy1 : busy0;
      rv[i]  = sel ? ready1 : ready0;
      dv[i]  = sel ? done1 : done0;
      if (i == swap_at) begin
        if (sel) data1 = swap_d; else data0 = swap_d;
      end
      if (i == drop_at) begin
        if (sel) valid1 = 1'b0; else valid0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
      bad++; $display("FAIL reset_even: got %b want 1100", {tx0, ready0, busy0, done0});
    end
    total++;
    if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
      bad++; $display("FAIL reset_odd: got %b want 1100", {tx1, ready1, busy1, done1});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
      bad++; $display("FAIL idle_after_reset: got %b want 1100", {tx0, ready0, busy0, done0});
    end
  endtask

  task automatic test_frame(input bit sel, input logic [3:0] d, input logic p, input string name);
    logic [127:0] txv, bv, rv, dv, etx, eb;
    send(sel, d);
    capture(sel, FL + 2, 0, -1, 4'd0, txv, bv, rv, dv);
    etx = put_frame(mask(FL + 2), d, p, 0);
    eb  = span(0, FL);
    total++;
    if (txv !== etx) begin bad++; $display("FAIL %s_line: got %h want %h", name, txv, etx); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL %s_busy: got %h want %h", name, bv, eb); end
    total++;
    if (rv !== (mask(FL + 2) & ~eb)) begin
      bad++; $display("FAIL %s_ready: got %h want %h", name, rv, mask(FL + 2) & ~eb);
    end
    total++;
    if (dv !== span(FL, 1)) begin bad++; $display("FAIL %s_done: got %h want %h", name, dv, span(FL, 1)); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] txv, bv, rv, dv, etx, eb, ed;
    int n;
    n = 2 * FL + 3;
    send(1'b0, 4'd9);
    // valid stays high through frame 1 and is dropped in the first START cycle of frame 2.
    capture(1'b0, n, FL + 1, 0, 4'd6, txv, bv, rv, dv);
    etx = put_frame(put_frame(mask(n), 4'd9, 1'b0, 0), 4'd6, 1'b0, FL + 1);
    eb  = span(0, FL) | span(FL + 1, FL);
    ed  = span(FL, 1) | span(2 * FL + 1, 1);
    total++;
    if (txv !== etx) begin bad++; $display("FAIL b2b_line: got %h want %h", txv, etx); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL b2b_busy: got %h want %h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL b2b_done: got %h want %h", dv, ed); end
  endtask

  task automatic test_data_change();
    logic [127:0] txv, bv, rv, dv, etx;
    send(1'b0, 4'd3);
    capture(1'b0, FL + 2, 0, 0, 4'd12, txv, bv, rv, dv);
    etx = put_frame(mask(FL + 2), 4'd3, 1'b0, 0);
    total++;
    if (txv !== etx) begin bad++; $display("FAIL data_change_line: got %h want %h", txv, etx); end
  endtask

  task automatic test_midframe_reset();
    logic quiet;
    send(1'b0, 4'd5);
    @(negedge clk); valid0 = 1'b0;
    repeat (BC + 5) @(negedge clk);
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b want 1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
      bad++; $display("FAIL midframe_reset: got %b want 1100", {tx0, ready0, busy0, done0});
    end
    @(negedge clk); rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < FL + 8; i++) begin
      @(negedge clk);
      if ({tx0, ready0, busy0, done0} !== 4'b1100) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL post_reset_quiet: got %b want 1", quiet); end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 4'd5, 1'b0, "even5");
    test_frame(1'b0, 4'd7, 1'b1, "even7");
    test_frame(1'b1, 4'd7, 1'b0, "odd7");
    test_frame(1'b1, 4'd0, 1'b1, "odd0");
    test_frame(1'b0, 4'd1, 1'b1, "even1");
    test_back_to_back();
    test_data_change();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Serial framing transmitter that sits on the sending side of the nibble even/odd parity path. The existing even/odd block classifies received data; this block generates the parity.
- Accepts a DATA_W-bit word through a valid/ready handshake.
- Computes a parity bit and shifts out one frame on a single line: start bit, data LSB-first, parity bit, stop bit.
- Each bit is held for BIT_CYCLES clocks.

Parameters:
- DATA_W, 4: payload width in bits (>=1).
- BIT_CYCLES, 4: clocks per serial bit (>=1).
- PARITY_ODD, 0: 0 = even parity (total ones in data+parity is even); 1 = odd parity.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  word to transmit; sampled only on accept.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idle high.
- busy  output  1  frame in progress (START through STOP).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tx_out=1, ready_out=1, busy=0, done=0, bit and cycle counters=0, shift register=0. Reset mid-frame aborts the frame immediately, with no partial-frame completion and no done pulse.
- Accept: on a rising edge with valid_in=1 and ready_out=1, the block latches data_in and the computed parity and moves to START.
- Parity value: the XOR of all data bits, inverted when PARITY_ODD=1.
- valid_in while ready_out=0 is ignored. No queueing and no error.
- Changes on data_in after accept have no effect on the frame.
- States and outputs:
  - IDLE: tx_out=1, ready_out=1, busy=0.
  - START: tx_out=0.
  - DATA: tx_out=shift[0]; the register shifts right after each bit. Bit counter runs 0..DATA_W-1.
  - PARITY: tx_out=parity bit.
  - STOP: tx_out=1.
- Busy: busy=1 and ready_out=0 in START, DATA, PARITY and STOP.
- Bit timing: a cycle counter counts 0..BIT_CYCLES-1 in each state and advances the state at BIT_CYCLES-1. The counter wraps to 0 on every state change.
- Latency: first cycle of start bit = the cycle after the accept edge.
- Frame length = (DATA_W+3)*BIT_CYCLES clocks; 28 with defaults.
- Completion: after the last STOP cycle, the next edge enters IDLE and done=1 for exactly that one IDLE cycle. ready_out is also 1 in that cycle, so a back-to-back accept is legal. If that accept happens, START begins on the following cycle and the line shows no extra idle beyond that one cycle.
- BIT_CYCLES=1: one clock per bit; counter is always 0.
- All outputs are registered or decoded from state only; no combinational path from valid_in or data_in to any output.

Optional Feature:
- Macro: TX_DOUBLE_STOP_EN
- Defined: STOP lasts 2*BIT_CYCLES clocks (two stop bits). Frame length = (DATA_W+4)*BIT_CYCLES, i.e. 32 with defaults. done still pulses once, after the second stop bit.
- Undefined: single stop bit, as specified above.

Test Plan:
- Reset check: assert rst_n=0 at any time, including mid-DATA -> tx_out=1, ready_out=1, busy=0, done=0 within the same cycle. No further line activity until a new accept.
- Even parity, data=4'd5, BIT_CYCLES=4 -> tx_out sequence 0,1,0,1,0,0,1, each held 4 clocks. busy=1 for 28 clocks. done pulses 1 clock, then tx_out stays 1.
- Even parity, data=4'd7 -> parity bit 1. Odd parity (PARITY_ODD=1), data=4'd7 -> parity bit 0. Odd parity, data=4'd0 -> parity bit 1.
- Hold valid_in=1 with data_in=4'd9 then 4'd6 continuously -> two back-to-back frames with exactly one idle-high cycle (the done cycle) between them. Second frame carries 4'd6 and parity 0. valid_in during busy causes no extra frame.
- Change data_in from 4'd3 to 4'd12 one cycle after accept -> transmitted data bits remain 1,1,0,0 with even parity 0.
- With TX_DOUBLE_STOP_EN, data=4'd1 -> stop-high period is 8 clocks, total frame 32 clocks, single done pulse.
